// File: rtl/ps2_pkg.sv
// Shared PS/2 link definitions used by the receiver and the link driver.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam int unsigned PS2_FRAME_BITS = 11;

  // Parity bit that makes the 9-bit {data, parity} word have an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus persistence filter for one asynchronous PS/2 line.
module ps2_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q;
  logic                   out_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      cnt_q  <= '0;
      out_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      // cnt_q counts how long the synchronised value has disagreed with the output.
      if (synced == out_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        out_q <= synced;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign out = out_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: filtered line sampling, 11-bit frame FSM,
// valid/ready holding register and one-cycle error pulses.
module ps2_rx import ps2_pkg::*; #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_timeout,
  output logic       overrun
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES);

  logic              clk_f, dat_f, clk_f_q, fall;
  rx_state_t         state_q, state_d;
  logic [3:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic              parity_q;
  logic [TimerW-1:0] timer_q;
  logic [7:0]        rx_data_q;
  logic              rx_valid_q, err_parity_q, err_frame_q, overrun_q;
  logic              timeout_hit, step, stop_step, good_frame;

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk  (clk),
    .reset(reset),
    .in   (ps2_clk),
    .out  (clk_f)
  );

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_dat_filter (
    .clk  (clk),
    .reset(reset),
    .in   (ps2_dat),
    .out  (dat_f)
  );

  assign fall = clk_f_q & ~clk_f;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a timeout overrides any fall seen in the same cycle.
  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = IDLE;
    end else if (fall) begin
      unique case (state_q)
        IDLE:    if (!dat_f) state_d = DATA;
        DATA:    if (bit_cnt_q == 4'(PS2_DATA_BITS - 1)) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Decoded frame events.
  always_comb begin
    timeout_hit = (state_q != IDLE) && (timer_q == TimerMax);
    step        = fall && !timeout_hit;
    stop_step   = step && (state_q == STOP);
    good_frame  = stop_step && dat_f && (parity_q == odd_parity(shift_q));
    err_timeout = timeout_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_f_q      <= 1'b1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      timer_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      clk_f_q      <= clk_f;
      err_frame_q  <= stop_step && !dat_f;
      err_parity_q <= stop_step && dat_f && (parity_q != odd_parity(shift_q));
      overrun_q    <= good_frame && rx_valid_q && !rx_ready;

      if (state_q == IDLE || timeout_hit || fall) begin
        timer_q <= '0;
      end else if (timer_q != TimerMax) begin
        timer_q <= timer_q + TimerW'(1);
      end

      if (timeout_hit) begin
        bit_cnt_q <= '0;
      end else if (step) begin
        unique case (state_q)
          IDLE: bit_cnt_q <= '0;
          DATA: begin
            shift_q   <= {dat_f, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
          PARITY:  parity_q <= dat_f;
          default: ;
        endcase
      end

      // A same-cycle transfer frees the register, so a new byte may replace it.
      if (good_frame && (!rx_valid_q || rx_ready)) begin
        rx_data_q  <= shift_q;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign err_parity = err_parity_q;
  assign err_frame  = err_frame_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- Synchronous receiver for the device-to-host PS/2-style serial link (open-collector clk/dat pair) produced by the link driver.
- Oversamples both lines with the system clock, filters them, and deserialises 11-bit frames.
- Frame format: start 0, 8 data bits LSB first, odd parity, stop 1.
- Delivers bytes over a valid/ready holding register and reports parity, framing, timeout and overrun errors as one-cycle pulses.

Parameters:
- SYNC_STAGES, 2: flip-flop synchroniser depth on ps2_clk and ps2_dat (minimum 2).
- FILTER_LEN, 4: consecutive identical synchronised samples required before the filtered line changes (minimum 1).
- TIMEOUT_CYCLES, 2000: system cycles allowed between falling edges inside a frame before the frame is abandoned.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  link clock, asynchronous to clk; idle high.
- ps2_dat  in  1  link data, asynchronous to clk; idle high.
- rx_data  out  8  received byte; stable while rx_valid.
- rx_valid  out  1  byte held in rx_data.
- rx_ready  in  1  consumer accepts; transfer occurs when rx_valid && rx_ready.
- err_parity  out  1  one-cycle pulse: parity bit incorrect.
- err_frame  out  1  one-cycle pulse: stop bit sampled 0.
- err_timeout  out  1  one-cycle pulse: frame abandoned mid-way.
- overrun  out  1  one-cycle pulse: good frame completed while rx_valid still high.

Behaviour:
- Reset, asynchronous, while asserted:
  - Synchroniser and filter registers go to 1.
  - State goes to IDLE; bit count, shift register and timer go to 0.
  - rx_data = 0; rx_valid, err_parity, err_frame, err_timeout and overrun = 0.
- Reset mid-frame discards the partial frame; no error is reported.
- Input path:
  - Each line passes SYNC_STAGES flops, then the filter.
  - The filtered value takes the synchronised value once that value has held for FILTER_LEN consecutive cycles.
- Falling edge event: fall is asserted for one cycle when filtered ps2_clk goes 1→0. Filtered ps2_dat is sampled in that same cycle. Rising edges are ignored.
- FSM, one transition per fall:
  - IDLE: sampled 0 → DATA with bit count 0 and timer cleared. Sampled 1 → stay IDLE, no flag.
  - DATA: shift the sample in at the MSB, shifting right (LSB arrives first). Increment the count; after the 8th bit go to PARITY.
  - PARITY: store the sample, then go to STOP.
  - STOP, always returns to IDLE, checks in this priority:
    - Sample 0 → err_frame.
    - Else XOR of 8 data bits and parity bit = 0 → err_parity.
    - Else good frame.
  - Only one error pulse per frame. Errored frames never touch rx_data or rx_valid.
- Good frame delivery:
  - rx_valid == 0: rx_data ← shift register and rx_valid ← 1 on the cycle after the stop-bit fall.
  - rx_valid == 1 and rx_ready == 0 that cycle: pulse overrun, keep the old byte, drop the new one.
  - rx_valid == 1 and rx_ready == 1 that cycle: the transfer completes and the new byte loads. rx_valid stays 1 and overrun is not raised.
- rx_valid clears the cycle after rx_valid && rx_ready when no new byte loads.
- Latency, pin fall of the stop bit to rx_valid: SYNC_STAGES + FILTER_LEN + 1 cycles. This is 7 with the defaults.
- Timeout:
  - In DATA, PARITY or STOP the timer counts every cycle and clears on each fall.
  - When the timer reaches TIMEOUT_CYCLES: pulse err_timeout, go to IDLE, clear the bit count. That cycle's fall, if any, is ignored.
  - The timer is held at 0 in IDLE.
- Width rules:
  - Bit count is 4 bits.
  - Timer is $clog2(TIMEOUT_CYCLES+1) bits and saturates, never wrapping.

Decomposition:
- Shared package ps2_pkg:
  - State enum rx_state_t {IDLE, DATA, PARITY, STOP}.
  - Constants PS2_DATA_BITS = 8, PS2_FRAME_BITS = 11.
  - Function odd_parity(byte).
  - The link driver uses the same package.
- Sub-module ps2_line_filter (parameters SYNC_STAGES, FILTER_LEN; ports clk, reset, in, out).
  - Instantiated twice, once per line.
  - The top level performs edge detection on the clock-line instance output.

Test Plan:
- Bench setup: 1 µs system clock; PS/2 bit period 80 µs (data change, 20 µs, clock low 40 µs, clock high).
- Bytes 0x00–0x0F back to back, rx_ready tied 1 → 16 rx_valid pulses carrying 0x00..0x0F in order; no error pulses; each rx_valid appears 7 cycles after the stop-bit pin fall.
- Byte 0xA5 with parity bit 0 (correct is 1) → single err_parity pulse; rx_valid stays 0. A following good 0x07 (parity 0) → rx_data = 0x07.
- Byte 0x3C with stop bit 0 → err_frame pulse, no rx_valid. The following good frame 0x3C is received correctly.
- Clocking stops after 4 data bits → err_timeout exactly TIMEOUT_CYCLES cycles after the last filtered fall. A subsequent full frame 0x5A → rx_data = 0x5A.
- rx_ready = 0; send 0x11 then 0x22 → rx_valid = 1 with 0x11, overrun pulse on completion of 0x22, rx_data still 0x11. Raise rx_ready for one cycle → rx_valid drops next cycle.
- Assert reset after 5 data bits of 0x99 → all outputs 0 immediately. Release, send 0x42 → only 0x42 is delivered, no errors.
